// File: rtl/priority_scan_seq.sv
// -----------------------------------------------------------------------------
// priority_scan_seq
//
// Serialises a request vector into a stream of its set bits, lowest index
// first. An accepted vector is copied into a remainder register. Each output
// transfer clears the bit just emitted, so the next-lowest set bit becomes
// the new priority bit. Typical uses are interrupt masks, request masks and
// valid masks that have to become an indexed stream.
//
// Parameters
//   WIDTH      vector width (>= 2)
//   WIDTH_LOG  index width, $clog2(WIDTH)
//
// Ports
//   clk      clock; all state changes on the rising edge
//   rst      synchronous active-high reset
//   in_vld   input vector valid
//   in_rdy   block can accept a vector
//   in_vec   request vector to scan
//   out_vld  output element valid
//   out_rdy  consumer accepts the element
//   out_oht  one-hot of the lowest set bit still pending
//   out_idx  binary index of out_oht
//   out_lst  current element is the last set bit of the vector
//
// Optional build macro
//   PRIORITY_SCAN_OVERLAP_EN  allows the next vector to be accepted in the
//                             same cycle the last element of the current
//                             vector transfers. Back-to-back vectors then
//                             run without a bubble. When the macro is not
//                             defined, one idle cycle separates vectors.
// -----------------------------------------------------------------------------
module priority_scan_seq #(
  parameter  int WIDTH     = 32,
  localparam int WIDTH_LOG = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [WIDTH-1:0]     in_vec,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [WIDTH-1:0]     out_oht,
  output logic [WIDTH_LOG-1:0] out_idx,
  output logic                 out_lst
);

  if (WIDTH < 2) begin : g_bad_width
    $error("priority_scan_seq: WIDTH must be >= 2");
  end

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t               state_q;
  logic [WIDTH-1:0]     rem_q;
  logic [WIDTH-1:0]     rem_d;     // remainder after the current bit is emitted
  logic [WIDTH-1:0]     low_oht;   // lowest set bit of rem_q
  logic                 rest_zero; // only one bit is left in rem_q
  logic [WIDTH_LOG-1:0] idx_d;
  logic                 in_xfer;
  logic                 out_xfer;
  logic                 vec_nz;

  // Two's-complement trick: rem & -rem isolates the lowest set bit.
  // rem & (rem-1) clears that bit, so a zero result means it was the last one.
  assign low_oht   = rem_q & (-rem_q);
  assign rest_zero = ((rem_q & (rem_q - ONE)) == '0);
  assign rem_d     = rem_q & ~low_oht;
  assign vec_nz    = (in_vec != '0);

  // low_oht is one-hot or zero, so OR-ing the set positions is a valid encoder.
  always_comb begin
    idx_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (low_oht[i]) idx_d = idx_d | WIDTH_LOG'(i);
    end
  end

  // All outputs come from registers only. rem_q is zero in IDLE, so
  // out_oht and out_idx are already zero there. out_lst must be masked,
  // because the "one bit left" test is also true when rem_q is empty.
  assign out_vld = (state_q == SCAN);
  assign out_oht = low_oht;
  assign out_idx = idx_d;
  assign out_lst = out_vld & rest_zero;

  assign out_xfer = out_vld & out_rdy;

`ifdef PRIORITY_SCAN_OVERLAP_EN
  // The last element leaving frees the block in the same cycle.
  assign in_rdy = ~rst & ((state_q == IDLE) | (out_xfer & out_lst));
`else
  assign in_rdy = ~rst & (state_q == IDLE);
`endif

  assign in_xfer = in_vld & in_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // An all-zero vector is consumed silently and produces no output.
          if (in_xfer && vec_nz) begin
            rem_q   <= in_vec;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (out_xfer) begin
            if (!out_lst) begin
              rem_q <= rem_d;
`ifdef PRIORITY_SCAN_OVERLAP_EN
            end else if (in_xfer && vec_nz) begin
              // Hand straight over to the next vector; stay in SCAN.
              rem_q <= in_vec;
`endif
            end else begin
              rem_q   <= '0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          rem_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_priority_scan_seq.sv
module tb_priority_scan_seq;
  localparam int W  = 8;
  localparam int WL = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_vld = 1'b0;
  logic          in_rdy;
  logic [W-1:0]  in_vec = '0;
  logic          out_vld;
  logic          out_rdy = 1'b0;
  logic [W-1:0]  out_oht;
  logic [WL-1:0] out_idx;
  logic          out_lst;

  typedef struct {
    logic [WL-1:0] idx;
    logic [W-1:0]  oht;
    logic          lst;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   t0;

  priority_scan_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .in_vld (in_vld),
    .in_rdy (in_rdy),
    .in_vec (in_vec),
    .out_vld(out_vld),
    .out_rdy(out_rdy),
    .out_oht(out_oht),
    .out_idx(out_idx),
    .out_lst(out_lst)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: an output transfer at the next rising edge is visible here.
  always @(negedge clk) begin
    if (!rst && out_vld === 1'b1 && out_rdy) begin
      if (sb.size() == 0) begin
        n_assert++;
        assert (sb.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_out observed idx=%0d expected=no output", out_idx);
        end
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_idx", 32'(out_idx), 32'(e.idx));
        chk("sb_oht", 32'(out_oht), 32'(e.oht));
        chk("sb_lst", 32'(out_lst), 32'(e.lst));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push the expected elements, then present the vector until it is accepted.
  task automatic send(input logic [W-1:0] v);
    exp_t e;
    bit   acc;
    int   n;
    for (int i = 0; i < W; i++) begin
      if (v[i]) begin
        e.idx = WL'(i);
        e.oht = W'(1) << i;
        e.lst = ((v >> (i + 1)) == '0);
        sb.push_back(e);
      end
    end
    in_vld = 1'b1;
    in_vec = v;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = in_rdy;
      @(posedge clk);
      #1;
      n++;
    end
    n_assert++;
    assert (acc) else begin
      n_fail++;
      $error("FAIL send_timeout observed=not accepted expected=accepted vec=%0h", v);
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      step();
      n++;
    end
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    // Reset held with a valid vector present
    rst = 1'b1; in_vld = 1'b1; in_vec = 8'hFF;
    repeat (3) begin
      step();
      chk("rst_in_rdy", 32'(in_rdy), 32'd0);
      chk("rst_out_vld", 32'(out_vld), 32'd0);
    end
    rst = 1'b0; in_vld = 1'b0;
    #1;
    chk("post_rst_in_rdy", 32'(in_rdy), 32'd1);
    chk("post_rst_vld", 32'(out_vld), 32'd0);
    chk("post_rst_oht", 32'(out_oht), 32'd0);
    chk("post_rst_idx", 32'(out_idx), 32'd0);
    chk("post_rst_lst", 32'(out_lst), 32'd0);
    repeat (3) begin
      step();
      chk("post_rst_quiet", 32'(out_vld), 32'd0);
    end

    // Basic scan: elements 2,5,7
    out_rdy = 1'b1;
    send(8'hA4);
    in_vld = 1'b0;
    chk("scan_lat_vld", 32'(out_vld), 32'd1);
    chk("scan_first_idx", 32'(out_idx), 32'd2);
    chk("scan_busy_rdy", 32'(in_rdy), 32'd0);
    drain("scan_drain");

    // Backpressure holds the current element stable
    out_rdy = 1'b0;
    send(8'h81);
    in_vld = 1'b0;
    repeat (4) begin
      step();
      chk("bp_vld", 32'(out_vld), 32'd1);
      chk("bp_idx", 32'(out_idx), 32'd0);
      chk("bp_oht", 32'(out_oht), 32'h01);
    end
    out_rdy = 1'b1;
    drain("bp_drain");

    // Zero vector is consumed with no output
    send(8'h00);
    in_vld = 1'b0;
    chk("zero_in_rdy", 32'(in_rdy), 32'd1);
    chk("zero_vld", 32'(out_vld), 32'd0);
    step();
    chk("zero_vld2", 32'(out_vld), 32'd0);

    // Top bit only
    send(8'h80);
    in_vld = 1'b0;
    chk("top_idx", 32'(out_idx), 32'd7);
    chk("top_lst", 32'(out_lst), 32'd1);
    drain("top_drain");

    // All ones: 0..7
    send(8'hFF);
    in_vld = 1'b0;
    drain("ff_drain");

    // Reset during a scan discards the remaining bits
    send(8'hF0);
    in_vld = 1'b0;
    step();
    rst = 1'b1;
    sb.delete();
    step();
    rst = 1'b0;
    #1;
    chk("midrst_vld", 32'(out_vld), 32'd0);
    chk("midrst_in_rdy", 32'(in_rdy), 32'd1);
    repeat (3) begin
      step();
      chk("midrst_quiet", 32'(out_vld), 32'd0);
    end

    // Back-to-back vectors
    send(8'h03);
    t0 = cyc;
    send(8'h0C);
    in_vld = 1'b0;
    drain("ovl_drain");
`ifdef PRIORITY_SCAN_OVERLAP_EN
    chk("ovl_cycles", 32'(cyc - t0), 32'd4);
`else
    chk("ovl_cycles", 32'(cyc - t0), 32'd5);
`endif
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
